// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the bus initiator: FSM state encoding and default bus width.
// Imported by the command interface and the initiator itself.
package bus_initiator_pkg;

   localparam int BUS_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Command/response handshake bundle between a requester (master) and the bus initiator (slave).
// Both channels use valid/ready; data is held stable while valid is high and ready is low.
interface bus_initiator_if
   import bus_initiator_pkg::*;
#(
   parameter int BW = BUS_WIDTH_DEF
) ();

   logic          cmd_valid;
   logic          cmd_ready;
   logic [BW-1:0] cmd_addr;
   logic [BW-1:0] cmd_wdata;
   logic          cmd_rw;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [BW-1:0] rsp_rdata;
   logic          rsp_err;

   modport master (
      output cmd_valid, cmd_addr, cmd_wdata, cmd_rw, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_wdata, cmd_rw, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: issues one request into the core chain and waits for its return or a timeout.
// Latency: cmd handshake to rsp_valid is 2 cycles plus chain round trip; rsp is held until rsp_ready.
module bus_initiator
   import bus_initiator_pkg::*;
#(
   parameter int TIMEOUT   = 64,
   parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   bus_initiator_if.slave       cmd_bus,
   output logic [BUS_WIDTH-1:0] addr_o,
   output logic [BUS_WIDTH-1:0] wdata_o,
   output logic [BUS_WIDTH-1:0] rdata_o,
   output logic                 rw_o,
   output logic                 valid_o,
   input  logic [BUS_WIDTH-1:0] addr_i,
   input  logic [BUS_WIDTH-1:0] wdata_i,
   input  logic [BUS_WIDTH-1:0] rdata_i,
   input  logic                 rw_i,
   input  logic                 valid_i
);

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);
   localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

   state_t               r_state;
   logic [TW-1:0]        r_timer;
   logic [BUS_WIDTH-1:0] r_addr;
   logic [BUS_WIDTH-1:0] r_addr_o;
   logic [BUS_WIDTH-1:0] r_wdata_o;
   logic                 r_rw_o;
   logic                 r_valid_o;
   logic                 r_cmd_ready;
   logic                 r_rsp_valid;
   logic                 r_rsp_err;
   logic [BUS_WIDTH-1:0] r_rsp_rdata;

   logic w_match;
   logic w_unused;

   // Returns are matched on address only; the echoed rw/wdata carry no extra information.
   assign w_match  = valid_i && (addr_i == r_addr);
   assign w_unused = ^{rw_i, wdata_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_addr      <= '0;
         r_addr_o    <= '0;
         r_wdata_o   <= '0;
         r_rw_o      <= 1'b0;
         r_valid_o   <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_bus.cmd_valid && r_cmd_ready) begin
                  r_addr      <= cmd_bus.cmd_addr;
                  r_addr_o    <= cmd_bus.cmd_addr;
                  r_wdata_o   <= cmd_bus.cmd_wdata;
                  r_rw_o      <= cmd_bus.cmd_rw;
                  r_valid_o   <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_addr_o  <= '0;
               r_wdata_o <= '0;
               r_rw_o    <= 1'b0;
               r_valid_o <= 1'b0;
               r_timer   <= '0;
               r_state   <= ST_WAIT;
            end
            ST_WAIT: begin
               // A match in the cycle the timer expires still counts as a success.
               if (w_match) begin
                  r_rsp_rdata <= rdata_i;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (r_timer == TMO_LAST) begin
                  r_timer     <= r_timer + 1'b1;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (r_timer != TMR_MAX) begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_RESP: begin
               if (cmd_bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign addr_o  = r_addr_o;
   assign wdata_o = r_wdata_o;
   assign rdata_o = '0;
   assign rw_o    = r_rw_o;
   assign valid_o = r_valid_o;

   assign cmd_bus.cmd_ready = r_cmd_ready;
   assign cmd_bus.rsp_valid = r_rsp_valid;
   assign cmd_bus.rsp_err   = r_rsp_err;
   assign cmd_bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed vector table, reset corner cases and
// randomized transactions scored against a latency/result model derived from the timeout rules.
module tb_bus_initiator;

   localparam int T  = 8;
   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] addr_o, wdata_o, rdata_o;
   logic          rw_o, valid_o;
   logic [BW-1:0] addr_i  = '0;
   logic [BW-1:0] wdata_i = '0;
   logic [BW-1:0] rdata_i = '0;
   logic          rw_i    = 1'b0;
   logic          valid_i = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   bus_initiator_if #(.BW(BW)) bus ();

   bus_initiator #(.TIMEOUT(T), .BUS_WIDTH(BW)) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd_bus (bus.slave),
      .addr_o  (addr_o),
      .wdata_o (wdata_o),
      .rdata_o (rdata_o),
      .rw_o    (rw_o),
      .valid_o (valid_o),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_i (rdata_i),
      .rw_i    (rw_i),
      .valid_i (valid_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] wd;
      logic        rw;
      int          d;     // cycle (ISSUE = 0) at which the matching return is presented
      logic [15:0] rd;
      int          md;    // cycle of a non-matching return, -1 for none
      logic [15:0] ma;
      int          bp;    // cycles rsp_ready is held low
      int          lat;   // expected rsp_valid cycle relative to ISSUE
      logic        err;
      logic [15:0] erd;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: a return is seen only in WAIT cycles 1..T-1 after ISSUE, otherwise the timeout fires at T.
   function automatic void model(input int d, input logic [15:0] rd,
                                 output int lat, output logic err, output logic [15:0] erd);
      if (d >= 1 && d <= T - 1) begin
         lat = d + 1;
         err = 1'b0;
         erd = rd;
      end else begin
         lat = T;
         err = 1'b1;
         erd = 16'h0000;
      end
   endfunction

   task automatic do_txn(input string tag, input vec_t v, input logic cv_hold);
      int lat;
      int bad_bus;
      int bad_hold;
      chk({tag, ":cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = v.a;
      bus.cmd_wdata = v.wd;
      bus.cmd_rw    = v.rw;
      step();
      chk({tag, ":issue_valid_o"}, 32'(valid_o), 32'd1);
      chk({tag, ":issue_fields"}, {rdata_o[14:0], rw_o, addr_o}, {15'd0, v.rw, v.a});
      chk({tag, ":issue_wdata_o"}, 32'(wdata_o), 32'(v.wd));
      chk({tag, ":issue_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = cv_hold;
      bus.cmd_addr  = 16'($urandom);
      bus.cmd_wdata = 16'($urandom);
      bus.cmd_rw    = 1'($urandom);
      lat = -1;
      bad_bus = 0;
      for (int j = 0; j < T + 4 && lat < 0; j++) begin
         valid_i = 1'b0;
         if (j == v.d) begin
            valid_i = 1'b1; addr_i = v.a; rdata_i = v.rd; wdata_i = v.wd; rw_i = v.rw;
         end else if (j == v.md) begin
            valid_i = 1'b1; addr_i = v.ma; rdata_i = 16'($urandom); wdata_i = v.wd; rw_i = v.rw;
         end
         step();
         if (valid_o || rw_o || addr_o != 0 || wdata_o != 0 || rdata_o != 0) bad_bus++;
         if (bus.rsp_valid) lat = j + 1;
      end
      valid_i = 1'b0;
      chk({tag, ":rsp_latency"}, 32'(lat), 32'(v.lat));
      chk({tag, ":bus_idle_after_issue"}, 32'(bad_bus), 32'd0);
      chk({tag, ":rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
      chk({tag, ":rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.erd));
      bad_hold = 0;
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < v.bp; k++) begin
         valid_i = 1'b1; addr_i = v.a; rdata_i = 16'($urandom);
         step();
         if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_rdata !== v.erd || bus.rsp_err !== v.err)
            bad_hold++;
      end
      valid_i = 1'b0;
      if (v.bp > 0) chk({tag, ":rsp_hold"}, 32'(bad_hold), 32'd0);
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk({tag, ":rsp_valid_after_hs"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, ":cmd_ready_after_hs"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete within time limit");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   seen;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_rw    = 1'b0;
      bus.rsp_ready = 1'b0;

      tbl[0] = '{16'h0004, 16'h0000, 1'b0, 5,  16'hBEEF, -1, 16'h0000, 0,  6, 1'b0, 16'hBEEF};
      tbl[1] = '{16'h0007, 16'h1234, 1'b1, 3,  16'h0000, -1, 16'h0000, 0,  4, 1'b0, 16'h0000};
      tbl[2] = '{16'h0021, 16'h0000, 1'b0, 99, 16'hDEAD, -1, 16'h0000, 0,  8, 1'b1, 16'h0000};
      tbl[3] = '{16'h0004, 16'h0000, 1'b0, 5,  16'h00AA, 2,  16'h0009, 0,  6, 1'b0, 16'h00AA};
      tbl[4] = '{16'h0010, 16'h0000, 1'b0, 1,  16'h7777, -1, 16'h0000, 10, 2, 1'b0, 16'h7777};
      tbl[5] = '{16'h0033, 16'h0F0F, 1'b1, 7,  16'h1111, -1, 16'h0000, 1,  8, 1'b0, 16'h1111};
      tbl[6] = '{16'h0044, 16'h0000, 1'b0, 8,  16'h2222, -1, 16'h0000, 0,  8, 1'b1, 16'h0000};
      tbl[7] = '{16'h0055, 16'h0000, 1'b0, 0,  16'h3333, 3,  16'h0155, 2,  8, 1'b1, 16'h0000};

      // Reset state, while asserted and right after release.
      step();
      step();
      chk("reset:valid_o", 32'(valid_o), 32'd0);
      chk("reset:bus_fields", {addr_o, wdata_o}, 32'd0);
      chk("reset:rsp", {bus.rsp_rdata, 14'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
      rst = 1'b0;
      step();
      chk("reset:cmd_ready_after_release", 32'(bus.cmd_ready), 32'd1);
      chk("reset:rsp_valid_after_release", 32'(bus.rsp_valid), 32'd0);

      for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), tbl[i], 1'b0);

      // Reset while waiting: the stale return must be dropped and a new command accepted.
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 16'h0030;
      bus.cmd_rw    = 1'b0;
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rst_wait:rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_wait:valid_o", 32'(valid_o), 32'd0);
      step();
      rst = 1'b0;
      valid_i = 1'b1; addr_i = 16'h0030; rdata_i = 16'h5A5A;
      step();
      valid_i = 1'b0;
      seen = 0;
      for (int k = 0; k < T + 2; k++) begin
         if (bus.rsp_valid) seen++;
         step();
      end
      chk("rst_wait:stale_return_ignored", 32'(seen), 32'd0);
      v = '{16'h0030, 16'h0000, 1'b0, 2, 16'h4321, -1, 16'h0000, 0, 3, 1'b0, 16'h4321};
      do_txn("rst_wait:new_cmd", v, 1'b0);

      // Randomized transactions against the reference model.
      for (int n = 0; n < 40; n++) begin
         v.a  = 16'($urandom_range(0, 15));
         v.wd = 16'($urandom);
         v.rw = 1'($urandom);
         v.d  = $urandom_range(0, 10);
         v.rd = 16'($urandom);
         v.md = $urandom_range(0, 10);
         if (v.md == v.d) v.md = -1;
         v.ma = v.a ^ 16'($urandom_range(1, 15));
         v.bp = $urandom_range(0, 3);
         model(v.d, v.rd, v.lat, v.err, v.erd);
         do_txn($sformatf("rand%0d", n), v, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles to wait for a returned transaction before flagging an error; legal range 2..65535.
REQ-002 Parameter BUS_WIDTH, default 16: width of the bus address and data fields.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  initiator can accept a command.
REQ-007 cmd_addr  input  BUS_WIDTH  target bus address.
REQ-008 cmd_wdata  input  BUS_WIDTH  write data (ignored for reads).
REQ-009 cmd_rw  input  1  1 = write, 0 = read.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_rdata  output  BUS_WIDTH  read data returned by the chain; 0 on error.
REQ-013 rsp_err  output  1  timeout occurred.
REQ-014 addr_o, wdata_o, rdata_o  output  BUS_WIDTH each  request fields driven into the head of the core chain.
REQ-015 rw_o, valid_o  output  1 each  request fields driven into the head of the core chain.
REQ-016 addr_i, wdata_i, rdata_i  input  BUS_WIDTH each  transaction fields returned from the tail of the core chain.
REQ-017 rw_i, valid_i  input  1 each  transaction fields returned from the tail of the core chain.

Function
REQ-018 The initiator SHALL be an FSM with states IDLE, ISSUE, WAIT and RESP, and SHALL allow one outstanding transaction.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready it SHALL latch addr, wdata and rw, then go to ISSUE next cycle.
REQ-020 ISSUE: lasts exactly 1 cycle.
  - valid_o=1, with addr_o, wdata_o and rw_o equal to the latched values, and rdata_o=0.
  - Next state is WAIT, with the timer cleared to 0.
REQ-021 In every state other than ISSUE, valid_o, addr_o, wdata_o, rdata_o and rw_o SHALL all be 0.
REQ-022 WAIT, matching return: valid_i=1 with addr_i equal to the latched addr.
  - Capture rdata_i into rsp_rdata.
  - Set rsp_err=0.
  - Go to RESP.
REQ-023 WAIT, non-matching return: valid_i=1 with any other addr_i SHALL be ignored.
REQ-024 WAIT, timer: it SHALL increment each cycle without a match; when it reaches TIMEOUT-1 with no match, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 If a match and the timeout fall in the same cycle, the match SHALL win (rsp_err=0).
REQ-026 Writes SHALL also wait for their returned transaction, which serves as the acknowledge; rsp_rdata then equals the rdata_i returned.
REQ-027 RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready=1; on that handshake cycle go to IDLE.
REQ-028 Outside RESP: rsp_valid=0 and cmd_ready=0 (except in IDLE, per REQ-019).
REQ-029 valid_i arriving in IDLE, ISSUE or RESP SHALL be ignored.
REQ-030 Timer width is $clog2(TIMEOUT+1); the timer SHALL saturate and never wrap.
REQ-031 Best-case latency, cmd handshake to rsp_valid: 2 cycles plus the chain's round-trip latency.

Reset
REQ-032 While rst=1 and on its release:
  - State is IDLE and the timer is 0.
  - All bus outputs are 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - cmd_ready=1 from the first cycle after release.
REQ-033 Reset asserted mid-transaction SHALL abandon it immediately; a later return of that transaction SHALL be ignored.

Structure
REQ-034 The shared bus package SHALL hold the FSM state typedef and the BUS_WIDTH default constant.
REQ-035 The block SHALL be a single module with no sub-modules; the timer is inline.

Verification
REQ-036 Read: cmd addr=0x0004, rw=0; chain model returns 0xBEEF after 5 cycles.
  - valid_o high for exactly 1 cycle with addr_o=0x0004.
  - Then rsp_valid=1, rsp_rdata=0xBEEF, rsp_err=0.
REQ-037 Write: addr=0x0007, wdata=0x1234, rw=1.
  - valid_o pulse with wdata_o=0x1234, rw_o=1.
  - Chain echoes the transaction, giving rsp_valid=1 with rsp_err=0.
REQ-038 Timeout: TIMEOUT=8 and the chain never returns.
  - rsp_valid=1 with rsp_err=1 and rsp_rdata=0 exactly 8 cycles after ISSUE.
REQ-039 Mismatch then match: a return with addr_i=0x0009 is ignored; a later return with addr_i=0x0004 and rdata_i=0x00AA completes with rsp_rdata=0x00AA.
REQ-040 Backpressure: hold rsp_ready=0 for 10 cycles.
  - rsp_valid and rsp_rdata stay stable and cmd_ready=0 throughout.
  - rsp_ready=1 gives IDLE on the next cycle.
REQ-041 Reset in WAIT: assert rst, then return the old transaction after release.
  - rsp_valid stays 0.
  - A new command is accepted with cmd_ready=1.
